// File: rtl/reorder_buffer_pkg.sv
// Shared reorder buffer constants and entry / commit record layouts.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH  = 16;
   localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
   localparam int ROB_DATA_W = 32;
   localparam int ROB_REG_W  = 5;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [ROB_REG_W-1:0]  rd;
      logic                  wr_reg;
      logic                  is_store;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry;

   typedef struct packed {
      logic                  valid;
      logic [ROB_TAG_W-1:0]  tag;
      logic [ROB_REG_W-1:0]  rd;
      logic [ROB_DATA_W-1:0] data;
      logic                  we;
      logic                  store;
   } rob_commit_bus;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer; the MSB is a wrap bit so full and empty can be told apart.
module rob_ptr
   import reorder_buffer_pkg::*;
#(
   parameter int W = ROB_TAG_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_reg;

   // Depth is a power of two, so a plain binary increment wraps the index and toggles the wrap bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg <= '0;
      end else if (clr) begin
         ptr_reg <= '0;
      end else if (inc) begin
         ptr_reg <= ptr_reg + 1'b1;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates on dispatch, completes from the CDB,
// and retires the head through a single registered valid/ready commit port.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int TAG_W  = ROB_TAG_W,
   parameter int DATA_W = ROB_DATA_W,
   parameter int REG_W  = ROB_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_en,
   input  logic [REG_W-1:0]  alloc_rd,
   input  logic              alloc_wr_reg,
   input  logic              alloc_is_store,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              rob_full,
   output logic              rob_empty,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic              commit_we,
   output logic              commit_store
);

   logic [TAG_W:0]   head_ptr;
   logic [TAG_W:0]   tail_ptr;
   logic [TAG_W-1:0] head_idx;
   logic [TAG_W-1:0] tail_idx;
   logic             alloc_fire;
   logic             head_ready;
   logic             commit_load;
   rob_entry         head_entry;
   rob_entry         entry_view [DEPTH];
   rob_commit_bus    commit_reg;

   assign head_idx  = head_ptr[TAG_W-1:0];
   assign tail_idx  = tail_ptr[TAG_W-1:0];
   assign rob_empty = (head_ptr == tail_ptr);
   assign rob_full  = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
   assign alloc_tag = tail_idx;

   // Full is judged on the registered pointers, so a same-cycle retire frees the slot only next cycle.
   assign alloc_fire  = alloc_en && !rob_full && !flush;
   assign head_entry  = entry_view[head_idx];
   assign head_ready  = head_entry.valid && head_entry.done;
   assign commit_load = head_ready && (!commit_reg.valid || commit_ready) && !flush;

   rob_ptr #(.W(TAG_W + 1)) u_head (
      .clk (clk),
      .rst (rst),
      .inc (commit_load),
      .clr (flush),
      .ptr (head_ptr)
   );

   rob_ptr #(.W(TAG_W + 1)) u_tail (
      .clk (clk),
      .rst (rst),
      .inc (alloc_fire),
      .clr (flush),
      .ptr (tail_ptr)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         rob_entry entry_reg;
         logic     alloc_hit;
         logic     cdb_hit;
         logic     retire_hit;

         assign alloc_hit  = alloc_fire && (tail_idx == TAG_W'(gi));
         assign cdb_hit    = cdb_valid && (cdb_tag == TAG_W'(gi)) && entry_reg.valid && !entry_reg.done;
         assign retire_hit = commit_load && (head_idx == TAG_W'(gi));

         // Allocation only targets an invalid slot, so it never collides with a CDB hit or a retire.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               entry_reg <= '0;
            end else if (flush) begin
               entry_reg.valid <= 1'b0;
               entry_reg.done  <= 1'b0;
            end else if (alloc_hit) begin
               entry_reg.valid    <= 1'b1;
               entry_reg.done     <= 1'b0;
               entry_reg.rd       <= alloc_rd;
               entry_reg.wr_reg   <= alloc_wr_reg;
               entry_reg.is_store <= alloc_is_store;
               entry_reg.data     <= '0;
            end else begin
               if (retire_hit) begin
                  entry_reg.valid <= 1'b0;
               end
               if (cdb_hit) begin
                  entry_reg.done <= 1'b1;
                  entry_reg.data <= cdb_data;
               end
            end
         end

         assign entry_view[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_reg <= '0;
      end else if (flush) begin
         commit_reg.valid <= 1'b0;
      end else if (commit_load) begin
         commit_reg.valid <= 1'b1;
         commit_reg.tag   <= head_idx;
         commit_reg.rd    <= head_entry.rd;
         commit_reg.data  <= head_entry.data;
         commit_reg.we    <= head_entry.wr_reg;
         commit_reg.store <= head_entry.is_store;
      end else if (commit_ready) begin
         commit_reg.valid <= 1'b0;
      end
   end

   assign commit_valid = commit_reg.valid;
   assign commit_tag   = commit_reg.tag;
   assign commit_rd    = commit_reg.rd;
   assign commit_data  = commit_reg.data;
   assign commit_we    = commit_reg.we;
   assign commit_store = commit_reg.store;

endmodule
